complex_alu: RTL and testbench

//   Pipelined signed complex arithmetic unit: add, subtract or multiply a+bj operands.

---
 rtl/complex_alu.sv | 101 ++++++++++
 tb/tb_complex_alu.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/complex_alu.sv
// Two-stage pipelined signed complex ALU: add, subtract or multiply (a+bj) operands.
// Stage 1 registers op and operands; stage 2 computes and registers the result.
module complex_alu #(
  parameter int N = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  input  logic [1:0]       op,
  input  logic [N-1:0]     areal,
  input  logic [N-1:0]     aimaginary,
  input  logic [N-1:0]     breal,
  input  logic [N-1:0]     bimaginary,
  output logic             out_valid,
  output logic [2*N-1:0]   resultreal,
  output logic [2*N-1:0]   resultimaginary
);

  typedef enum logic [1:0] {
    OP_ADD = 2'b00,
    OP_SUB = 2'b01,
    OP_MUL = 2'b10,
    OP_RSV = 2'b11
  } op_e;

  op_e                    r_op;
  logic                   r_v1;
  logic signed [N-1:0]    r_ar, r_ai, r_br, r_bi;
  logic                   r_out_valid;
  logic [2*N-1:0]         r_re, r_im;

  logic signed [2*N-1:0]  w_ar_x, w_ai_x, w_br_x, w_bi_x;
  logic signed [2*N-1:0]  w_p_rr, w_p_ii, w_p_ri, w_p_ir;
  logic signed [N-1:0]    w_lo_re, w_lo_im;
  logic        [2*N-1:0]  w_re, w_im;

  // Operands widened first so each product is a full 2N-bit signed value.
  assign w_ar_x = {{N{r_ar[N-1]}}, r_ar};
  assign w_ai_x = {{N{r_ai[N-1]}}, r_ai};
  assign w_br_x = {{N{r_br[N-1]}}, r_br};
  assign w_bi_x = {{N{r_bi[N-1]}}, r_bi};

  assign w_p_rr = w_ar_x * w_br_x;
  assign w_p_ii = w_ai_x * w_bi_x;
  assign w_p_ri = w_ar_x * w_bi_x;
  assign w_p_ir = w_ai_x * w_br_x;

  // NOTE: every signal written here gets a value before any conditional branch,
  // so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    w_lo_re = r_ar + r_br;
    w_lo_im = r_ai + r_bi;
    if (r_op == OP_SUB) begin
      w_lo_re = r_ar - r_br;
      w_lo_im = r_ai - r_bi;
    end
    // Add/sub wrap at N bits and are then sign-extended; reserved op falls through as add.
    w_re = {{N{w_lo_re[N-1]}}, w_lo_re};
    w_im = {{N{w_lo_im[N-1]}}, w_lo_im};
    if (r_op == OP_MUL) begin
      w_re = w_p_rr - w_p_ii;
      w_im = w_p_ri + w_p_ir;
    end
  end

  // NOTE: pipeline state uses non-blocking assignments so every stage samples
  // the previous cycle's value of the stage before it.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_v1        <= 1'b0;
      r_op        <= OP_ADD;
      r_ar        <= '0;
      r_ai        <= '0;
      r_br        <= '0;
      r_bi        <= '0;
      r_out_valid <= 1'b0;
      r_re        <= '0;
      r_im        <= '0;
    end else begin
      r_v1 <= in_valid;
      if (in_valid) begin
        r_op <= op_e'(op);
        r_ar <= areal;
        r_ai <= aimaginary;
        r_br <= breal;
        r_bi <= bimaginary;
      end
      // Bubbles clear out_valid but leave the result ports at their last value.
      r_out_valid <= r_v1;
      if (r_v1) begin
        r_re <= w_re;
        r_im <= w_im;
      end
    end
  end

  assign out_valid       = r_out_valid;
  assign resultreal      = r_re;
  assign resultimaginary = r_im;

endmodule

// File: tb/tb_complex_alu.sv
// Scoreboard bench for complex_alu: stimulus pushes expected results computed with
// integer arithmetic; a negedge monitor pops and compares on out_valid.
module tb_complex_alu;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        in_valid = 1'b0;
  logic [1:0]  op = 2'b00;
  logic [7:0]  areal = '0, aimaginary = '0, breal = '0, bimaginary = '0;
  logic        out_valid;
  logic [15:0] resultreal, resultimaginary;

  complex_alu #(.N(8)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .op(op),
    .areal(areal), .aimaginary(aimaginary), .breal(breal), .bimaginary(bimaginary),
    .out_valid(out_valid), .resultreal(resultreal), .resultimaginary(resultimaginary)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] re;
    logic [15:0] im;
    int          due;
    string       name;
  } exp_t;

  exp_t sb[$];
  int   cyc = 0;
  int   n_checks = 0;
  int   n_fail = 0;
  bit   done = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reduce x modulo 2^bits into the signed range of a bits-wide word.
  function automatic int wrap(input int x, input int bits);
    int m = 1 << bits;
    int r = x % m;
    if (r < 0) r += m;
    if (r >= m / 2) r -= m;
    return r;
  endfunction

  // Reference model straight from the arithmetic definition of each op.
  function automatic void model(input int opc, input int ar, input int ai, input int br,
                                input int bi, output logic [15:0] re, output logic [15:0] im);
    int vr, vi;
    case (opc)
      1:       begin vr = wrap(ar - br, 8);            vi = wrap(ai - bi, 8); end
      2:       begin vr = wrap(ar * br - ai * bi, 16); vi = wrap(ar * bi + ai * br, 16); end
      default: begin vr = wrap(ar + br, 8);            vi = wrap(ai + bi, 8); end
    endcase
    re = 16'(vr);
    im = 16'(vi);
  endfunction

  task automatic issue(input int opc, input int ar, input int ai, input int br, input int bi,
                       input string name);
    exp_t e;
    @(negedge clk);
    in_valid   = 1'b1;
    op         = 2'(opc);
    areal      = 8'(ar);
    aimaginary = 8'(ai);
    breal      = 8'(br);
    bimaginary = 8'(bi);
    model(opc, ar, ai, br, bi, e.re, e.im);
    e.due  = cyc + 2;
    e.name = name;
    if (reset) sb.push_back(e);
  endtask

  task automatic bubble(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      in_valid   = 1'b0;
      areal      = 8'($urandom);
      breal      = 8'($urandom);
    end
  endtask

  function automatic int pick();
    case ($urandom_range(0, 5))
      0:       return -128;
      1:       return 127;
      2:       return -1;
      3:       return 0;
      default: return $urandom_range(0, 255) - 128;
    endcase
  endfunction

  // Monitor: pops the scoreboard whenever a result is presented.
  initial begin : monitor
    logic [15:0] last_re = '0, last_im = '0;
    exp_t e;
    forever begin
      @(negedge clk);
      if (done) break;
      if (!reset) begin
        last_re = '0;
        last_im = '0;
        continue;
      end
      while (sb.size() > 0 && sb[0].due < cyc) begin
        e = sb.pop_front();
        n_checks++;
        n_fail++;
        $display("FAIL %s missing: got no out_valid expected result at cycle %0d", e.name, e.due);
      end
      if (out_valid) begin
        if (sb.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected out_valid: got 1 expected 0 (cycle %0d)", cyc);
        end else begin
          e = sb.pop_front();
          check({e.name, " latency"}, 16'(cyc), 16'(e.due));
          check({e.name, " re"}, resultreal, e.re);
          check({e.name, " im"}, resultimaginary, e.im);
          last_re = e.re;
          last_im = e.im;
        end
      end else begin
        check("hold re", resultreal, last_re);
        check("hold im", resultimaginary, last_im);
      end
    end
  end

  initial begin : stim
    logic [15:0] r, i;
    int          opc;
    #1;
    check("reset out_valid", 16'(out_valid), 16'd0);
    check("reset re", resultreal, 16'd0);
    check("reset im", resultimaginary, 16'd0);
    @(negedge clk);
    reset = 1'b1;

    // Single add, then idle so the hold behaviour is observed.
    issue(0, 3, 4, 1, 2, "add");
    bubble(4);

    issue(1, 3, 4, 1, 2, "sub");
    issue(1, -128, 0, 1, 0, "sub wrap");
    issue(2, 3, 4, 1, 2, "mult");
    issue(2, -128, -128, -128, -128, "mult corner");
    bubble(3);

    // Back-to-back add, mult, sub.
    issue(0, 10, -20, 5, 7, "b2b add");
    issue(2, -7, 9, 11, -3, "b2b mult");
    issue(1, 100, -100, -50, 60, "b2b sub");
    bubble(4);

    // Asynchronous reset mid-cycle while a result is on the ports.
    issue(0, 3, 4, 1, 2, "pre-reset add");
    bubble(1);
    @(posedge clk);
    #2;
    reset = 1'b0;
    sb.delete();
    #1;
    check("async reset out_valid", 16'(out_valid), 16'd0);
    check("async reset re", resultreal, 16'd0);
    check("async reset im", resultimaginary, 16'd0);
    @(negedge clk);
    reset = 1'b1;
    bubble(3);

    // Reset lands with ops in flight; nothing may emerge afterwards.
    issue(0, 1, 1, 1, 1, "flushed 1");
    @(posedge clk);
    #2;
    reset = 1'b0;
    sb.delete();
    issue(2, 5, 5, 5, 5, "flushed 2");
    bubble(2);
    reset = 1'b1;
    bubble(5);

    issue(3, 1, 1, 2, 2, "reserved op");
    bubble(3);

    // Randomized traffic with occasional bubbles and corner operands.
    for (int k = 0; k < 300; k++) begin
      if ($urandom_range(0, 3) == 0) begin
        bubble(1);
      end else begin
        opc = $urandom_range(0, 3);
        issue(opc, pick(), pick(), pick(), pick(), "random");
      end
    end
    bubble(6);

    check("scoreboard drained", 16'(sb.size()), 16'd0);
    done = 1;
    @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: got timeout expected end of test");
    $fatal(1, "timeout");
  end

endmodule
